add_sub_serial: RTL and testbench
=================================

Name: add_sub_serial

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor. Processes DIGIT bits per clock, LSB first, and raises a one-cycle done pulse when the result is ready. Also reports status flags (Carry, Overflow, Zero, Negative). It is the sequential successor to the 8-bit combinational add/sub and serves as the arithmetic core for later datapath and ALU labs.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly, 1 <= DIGIT <= WIDTH; N = WIDTH/DIGIT steps

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request: begin an operation on A, B, Subtract
A  input  WIDTH  operand A (two's complement or unsigned)
B  input  WIDTH  operand B
Subtract  input  1  0 = A+B, 1 = A-B
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: Result and flags valid
Result  output  WIDTH  A+B or A-B, modulo 2^WIDTH
Carry  output  1  carry out of MSB (subtract: 1 = no borrow)
Overflow  output  1  signed overflow
Zero  output  1  Result == 0
Negative  output  1  Result[WIDTH-1]

Behaviour:
- Reset, sampled on rising clk when reset=1: state=IDLE; busy, done, Result, Carry, Overflow, Zero, Negative all 0. Overrides start. Mid-operation reset aborts the operation with no done.
- States: IDLE, RUN, DONE.
- IDLE (busy=0, done=0), start=1 at an edge:
  - Capture A and B into shift registers.
  - B' = Subtract ? ~B : B; carry register = Subtract (invert-and-add-one).
  - Step counter = 0; go to RUN.
- RUN (busy=1): each edge adds the low DIGIT bits of A_sh, B'_sh and the carry register.
  - Shift the DIGIT-bit sum into the internal result register from the MSB side.
  - Update the carry register; shift the operands right by DIGIT; increment the counter.
  - After the Nth RUN edge, go to DONE.
- Latency: done=1 in the cycle following the Nth edge after the start-sampling edge. WIDTH=8: DIGIT=1 gives 8 cycles, DIGIT=4 gives 2, DIGIT=8 gives 1.
- DONE (busy=0, done=1 for exactly one cycle):
  - Result, Carry, Overflow, Zero and Negative are registered outputs, updated on entry to DONE.
  - They hold their values until the next entry to DONE or a reset.
  - Next state is IDLE, or RUN if start=1 in DONE (back-to-back; operands captured as in IDLE).
- start while busy=1 is ignored; no queuing.
- A, B and Subtract are sampled only at the accepting edge. Changes during RUN have no effect.
- Flags:
  - Carry = final carry register.
  - Overflow = (A[MSB] == B'[MSB]) && (Result[MSB] != A[MSB]).
  - Zero = (Result == 0); Negative = Result[MSB].
- Wrap-around: Result is modulo 2^WIDTH; no saturation.

Test Plan:
All scenarios WIDTH=8, DIGIT=1 unless stated.
1. A=11, B=15, Subtract=0, start pulse -> busy high 8 cycles, done 8 cycles after start edge; Result=26, C=0, V=0, Z=0, N=0.
2. A=50, B=10, Subtract=1 -> Result=40, C=1, V=0, Z=0, N=0. Then A=10, B=50, Subtract=1 -> Result=216 (0xD8, -40), C=0, V=0, N=1.
3. Boundaries:
   - A=127, B=1, add -> Result=128, V=1, N=1, C=0.
   - A=200, B=56, add -> Result=0, Z=1, C=1, V=0.
   - A=128, B=1, sub -> Result=127, V=1, C=1.
4. Robustness (A=11, B=15, add): after start, change A/B every cycle and pulse start during RUN -> Result still 26, exactly one done, latency unchanged. Assert reset on cycle 4 of a run -> next cycle busy=0, done=0, Result=0, no done follows.
5. DIGIT=4: A=0xF0, B=0x10, add -> done 2 cycles after start, Result=0, C=1, Z=1. Assert start with A=3, B=5, sub in the done cycle -> second done 2 cycles later, Result=254, C=0, N=1.
6. DIGIT=8: A=0x7F, B=0x80, add -> done 1 cycle after start, Result=0xFF, C=0, V=0, N=1. Result/flags stay stable for 10 idle cycles.

Source files
------------

// File: rtl/add_sub_serial.sv
// Multi-cycle two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// one-cycle done pulse with registered Result and C/V/Z/N flags.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Subtract,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    // B is inverted at capture; the carry register supplies the +1 for subtraction.
    logic [WIDTH-1:0] b_eff;
    assign b_eff = Subtract ? ~B : B;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] sum_digit;
    assign chain[0] = carry_q;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_digit_adder
            assign sum_digit[gi] = a_sh_q[gi] ^ b_sh_q[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_sh_q[gi] & b_sh_q[gi])
                                 | (chain[gi] & (a_sh_q[gi] ^ b_sh_q[gi]));
        end
    endgenerate

    // Concatenating before slicing keeps the shift legal even when DIGIT == WIDTH.
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_step;
    assign res_cat  = {sum_digit, res_sh_q};
    assign res_step = res_cat[WIDTH+DIGIT-1:DIGIT];

    logic last_step;
    logic accept;
    assign last_step = (cnt_q == CW'(N - 1));
    assign accept    = start && (state_q != RUN);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;

        case (state_q)
            RUN: begin
                res_sh_d = res_step;
                carry_d  = chain[DIGIT];
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    state_d  = DONE;
                    result_d = res_step;
                    c_d      = chain[DIGIT];
                    v_d      = (a_msb_q == b_msb_q) && (res_step[WIDTH-1] != a_msb_q);
                    z_d      = (res_step == '0);
                    n_d      = res_step[WIDTH-1];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // IDLE and DONE both accept a new request (DONE allows back-to-back).
        if (accept) begin
            state_d  = RUN;
            a_sh_d   = A;
            b_sh_d   = b_eff;
            res_sh_d = '0;
            carry_d  = Subtract;
            cnt_d    = '0;
            a_msb_d  = A[WIDTH-1];
            b_msb_d  = b_eff[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign Result   = result_q;
    assign Carry    = c_q;
    assign Overflow = v_q;
    assign Zero     = z_q;
    assign Negative = n_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three instances (DIGIT = 1, 4, 8), vector table plus
// scoreboard of expected results checked whenever an instance pulses done.
module tb_add_sub_serial;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [3];
    logic       start_s [3];
    logic       sub_s   [3];
    logic [7:0] a_s     [3];
    logic [7:0] b_s     [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic [7:0] res_s   [3];
    logic       c_s     [3];
    logic       v_s     [3];
    logic       z_s     [3];
    logic       n_s     [3];

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]),
        .Subtract(sub_s[0]), .busy(busy_s[0]), .done(done_s[0]), .Result(res_s[0]),
        .Carry(c_s[0]), .Overflow(v_s[0]), .Zero(z_s[0]), .Negative(n_s[0]));

    add_sub_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]),
        .Subtract(sub_s[1]), .busy(busy_s[1]), .done(done_s[1]), .Result(res_s[1]),
        .Carry(c_s[1]), .Overflow(v_s[1]), .Zero(z_s[1]), .Negative(n_s[1]));

    add_sub_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .reset(rst_s[2]), .start(start_s[2]), .A(a_s[2]), .B(b_s[2]),
        .Subtract(sub_s[2]), .busy(busy_s[2]), .done(done_s[2]), .Result(res_s[2]),
        .Carry(c_s[2]), .Overflow(v_s[2]), .Zero(z_s[2]), .Negative(n_s[2]));

    int steps [3] = '{8, 2, 1};

    typedef struct {
        int         inst;
        logic [7:0] res;
        logic       c, v, z, n;
        int         cyc;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] res;
        logic       c, v, z, n;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [7:0] r,
                                input logic c, input logic v, input logic z, input logic n);
        exp_t e;
        e.inst = k; e.res = r; e.c = c; e.v = v; e.z = z; e.n = n; e.cyc = 0;
        return e;
    endfunction

    // Reference: 9-bit sum of A, ones-complemented B and the subtract carry-in.
    function automatic exp_t model(input int k, input logic [7:0] a, input logic [7:0] b,
                                   input logic sub);
        logic [7:0] bb;
        logic [8:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        return mk(k, full[7:0], full[8],
                  (a[7] == bb[7]) && (full[7] != a[7]), full[7:0] == 8'd0, full[7]);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_s[k]) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_done_inst%0d", k), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_instance", k, e.inst);
                    check("latency_cycle", cyc, e.cyc);
                    check("result", {24'd0, res_s[k]}, {24'd0, e.res});
                    check("flags_cvzn", {28'd0, c_s[k], v_s[k], z_s[k], n_s[k]},
                          {28'd0, e.c, e.v, e.z, e.n});
                end
            end
        end
    end

    task automatic start_op(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic sub, input exp_t e);
        exp_t ee;
        @(negedge clk);
        a_s[k] = a; b_s[k] = b; sub_s[k] = sub; start_s[k] = 1'b1;
        ee = e;
        ee.cyc = cyc + 1 + steps[k];
        sb.push_back(ee);
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int busy_cnt);
        bit found;
        found = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done_s[k]) found = 1;
            else begin
                if (busy_s[k]) busy_cnt++;
                @(negedge clk);
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    vec_t tbl[9];
    int   bc;
    exp_t e;

    initial begin
        tbl[0] = '{0, 8'd11,  8'd15, 1'b0, 8'd26,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0, 8'd50,  8'd10, 1'b1, 8'd40,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{0, 8'd10,  8'd50, 1'b1, 8'd216, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{0, 8'd127, 8'd1,  1'b0, 8'd128, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{0, 8'd200, 8'd56, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{0, 8'd128, 8'd1,  1'b1, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1, 8'h5A,  8'h33, 1'b0, 8'h8D,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1, 8'h00,  8'h01, 1'b1, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{2, 8'h80,  8'h80, 1'b1, 8'h00,  1'b1, 1'b0, 1'b1, 1'b0};

        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1; start_s[k] = 1'b0; sub_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state_inst%0d", k),
                  {19'd0, busy_s[k], done_s[k], res_s[k], c_s[k], v_s[k], z_s[k], n_s[k]}, 32'd0);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;

        // Table vectors, busy must last exactly N cycles.
        for (int i = 0; i < 9; i++) begin
            start_op(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].sub,
                     mk(tbl[i].inst, tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n));
            wait_done(tbl[i].inst, bc);
            check($sformatf("busy_cycles_vec%0d", i), bc, steps[tbl[i].inst]);
        end

        // Random vectors on each instance against the reference model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] ra, rb;
                logic       rs;
                ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
                start_op(k, ra, rb, rs, model(k, ra, rb, rs));
                wait_done(k, bc);
            end
        end

        // Inputs churn and start is re-asserted throughout RUN: no effect.
        @(negedge clk);
        a_s[0] = 8'd11; b_s[0] = 8'd15; sub_s[0] = 1'b0; start_s[0] = 1'b1;
        e = mk(0, 8'd26, 1'b0, 1'b0, 1'b0, 1'b0);
        e.cyc = cyc + 1 + steps[0];
        sb.push_back(e);
        for (int i = 0; i < steps[0]; i++) begin
            @(negedge clk);
            a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); sub_s[0] = 1'($urandom);
            start_s[0] = 1'b1;
        end
        @(negedge clk);
        start_s[0] = 1'b0;
        check("robust_done_seen", {31'd0, done_s[0]}, 32'd1);
        repeat (5) @(negedge clk);

        // Reset in the middle of a run aborts it without a done pulse.
        a_s[0] = 8'd11; b_s[0] = 8'd15; sub_s[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", {31'd0, busy_s[0]}, 32'd1);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        check("midrun_reset_state",
              {19'd0, busy_s[0], done_s[0], res_s[0], c_s[0], v_s[0], z_s[0], n_s[0]}, 32'd0);
        repeat (12) @(negedge clk);

        // DIGIT=4 back-to-back: new start accepted in the done cycle.
        start_op(1, 8'hF0, 8'h10, 1'b0, mk(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        wait_done(1, bc);
        a_s[1] = 8'd3; b_s[1] = 8'd5; sub_s[1] = 1'b1; start_s[1] = 1'b1;
        e = mk(1, 8'd254, 1'b0, 1'b0, 1'b0, 1'b1);
        e.cyc = cyc + 1 + steps[1];
        sb.push_back(e);
        @(negedge clk);
        start_s[1] = 1'b0;
        check("b2b_busy_after_done", {31'd0, busy_s[1]}, 32'd1);
        wait_done(1, bc);

        // DIGIT=8: single-cycle op, outputs then hold while idle.
        start_op(2, 8'h7F, 8'h80, 1'b0, mk(2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        wait_done(2, bc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_idle%0d", i),
                  {19'd0, busy_s[2], done_s[2], res_s[2], c_s[2], v_s[2], z_s[2], n_s[2]},
                  {19'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
